// File: rtl/crack_status_collector.sv
// Launches the parallel RC4 key-search cores, watches their done/found pulses,
// and condenses the outcome into the one-hot success / failure status for the LED controller.
module crack_status_collector #(
    parameter int NUM_CORES = 4,
    parameter int KEY_W     = 24
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [NUM_CORES-1:0]       core_done,
    input  logic [NUM_CORES-1:0]       core_found,
    input  logic [NUM_CORES*KEY_W-1:0] core_key,
    output logic [NUM_CORES-1:0]       core_start,
    output logic                       core_stop,
    output logic [NUM_CORES-1:0]       success_state,
    output logic                       failure,
    output logic [KEY_W-1:0]           found_key,
    output logic                       busy,
    output logic [31:0]                run_cycles
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_SUCCESS,
        S_FAIL
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_CORES-1:0] done_mask_q, done_mask_d;
    logic [NUM_CORES-1:0] success_state_q, success_state_d;
    logic                 failure_q, failure_d;
    logic [KEY_W-1:0]     found_key_q, found_key_d;
    logic [31:0]          run_cycles_q, run_cycles_d;
    logic [NUM_CORES-1:0] core_start_q, core_start_d;
    logic                 core_stop_q, core_stop_d;
    logic                 busy_q, busy_d;

    logic [NUM_CORES-1:0] hit;
    logic [NUM_CORES-1:0] new_mask;
    logic [NUM_CORES-1:0] win_onehot;
    logic [KEY_W-1:0]     win_key;

    // Priority pick: scanning high to low lets the lowest-index hit overwrite the rest.
    always_comb begin
        hit        = core_done & core_found;
        win_onehot = '0;
        win_key    = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                win_onehot    = '0;
                win_onehot[i] = 1'b1;
                win_key       = core_key[i*KEY_W +: KEY_W];
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        done_mask_d     = done_mask_q;
        success_state_d = success_state_q;
        failure_d       = failure_q;
        found_key_d     = found_key_q;
        run_cycles_d    = run_cycles_q;
        new_mask        = done_mask_q | core_done;

        case (state_q)
            S_IDLE, S_SUCCESS, S_FAIL: begin
                if (start) begin
                    state_d         = S_LAUNCH;
                    done_mask_d     = '0;
                    success_state_d = '0;
                    failure_d       = 1'b0;
                    found_key_d     = '0;
                    run_cycles_d    = '0;
                end
            end
            S_LAUNCH: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (run_cycles_q != 32'hFFFF_FFFF) begin
                    run_cycles_d = run_cycles_q + 32'd1;
                end
                // A hit beats exhaustion even when both land in the same cycle.
                if (hit != '0) begin
                    state_d         = S_SUCCESS;
                    success_state_d = win_onehot;
                    found_key_d     = win_key;
                    done_mask_d     = new_mask;
                end else begin
                    done_mask_d = new_mask;
                    if (&new_mask) begin
                        state_d   = S_FAIL;
                        failure_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        core_start_d = (state_d == S_LAUNCH) ? '1 : '0;
        core_stop_d  = (state_d == S_SUCCESS);
        busy_d       = (state_d == S_LAUNCH) || (state_d == S_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            done_mask_q     <= '0;
            success_state_q <= '0;
            failure_q       <= 1'b0;
            found_key_q     <= '0;
            run_cycles_q    <= '0;
            core_start_q    <= '0;
            core_stop_q     <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            done_mask_q     <= done_mask_d;
            success_state_q <= success_state_d;
            failure_q       <= failure_d;
            found_key_q     <= found_key_d;
            run_cycles_q    <= run_cycles_d;
            core_start_q    <= core_start_d;
            core_stop_q     <= core_stop_d;
            busy_q          <= busy_d;
        end
    end

    assign core_start    = core_start_q;
    assign core_stop     = core_stop_q;
    assign success_state = success_state_q;
    assign failure       = failure_q;
    assign found_key     = found_key_q;
    assign busy          = busy_q;
    assign run_cycles    = run_cycles_q;

endmodule

// File: tb/tb_crack_status_collector.sv
// Directed self-checking bench for crack_status_collector: success, exhaustion,
// priority, success-over-exhaustion, mid-run reset and restart from FAIL.
module tb_crack_status_collector;

    localparam int NUM_CORES = 4;
    localparam int KEY_W     = 24;

    logic                       clk;
    logic                       reset;
    logic                       start;
    logic [NUM_CORES-1:0]       core_done;
    logic [NUM_CORES-1:0]       core_found;
    logic [NUM_CORES*KEY_W-1:0] core_key;
    logic [NUM_CORES-1:0]       core_start;
    logic                       core_stop;
    logic [NUM_CORES-1:0]       success_state;
    logic                       failure;
    logic [KEY_W-1:0]           found_key;
    logic                       busy;
    logic [31:0]                run_cycles;

    int errorCount = 0;
    int checkCount = 0;

    crack_status_collector #(
        .NUM_CORES(NUM_CORES),
        .KEY_W    (KEY_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .core_done    (core_done),
        .core_found   (core_found),
        .core_key     (core_key),
        .core_start   (core_start),
        .core_stop    (core_stop),
        .success_state(success_state),
        .failure      (failure),
        .found_key    (found_key),
        .busy         (busy),
        .run_cycles   (run_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Inputs change 1 time unit after the rising edge, outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setKey(input int idx, input logic [KEY_W-1:0] val);
        core_key[idx*KEY_W +: KEY_W] = val;
    endtask

    task automatic applyStimulus(input logic [3:0] done, input logic [3:0] found);
        core_done  = done;
        core_found = found;
        tick();
        core_done  = '0;
        core_found = '0;
    endtask

    task automatic launch();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_start"},   32'(core_start), 32'h0);
        checkOutput({tag, "_stop"},    32'(core_stop), 32'h0);
        checkOutput({tag, "_success"}, 32'(success_state), 32'h0);
        checkOutput({tag, "_failure"}, 32'(failure), 32'h0);
        checkOutput({tag, "_key"},     32'(found_key), 32'h0);
        checkOutput({tag, "_busy"},    32'(busy), 32'h0);
        checkOutput({tag, "_cycles"},  run_cycles, 32'h0);
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        core_done  = '0;
        core_found = '0;
        core_key   = '0;
        tick();
        tick();
        reset = 1'b0;
        checkAllZero("reset");

        // Core 2 hits on the 10th RUN cycle.
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("launch_start", 32'(core_start), 32'hF);
        checkOutput("launch_busy",  32'(busy), 32'h1);
        tick();
        checkOutput("run_start_cleared", 32'(core_start), 32'h0);
        checkOutput("run_busy", 32'(busy), 32'h1);
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("run_start_ignored", 32'(core_start), 32'h0);
        for (int i = 0; i < 8; i++) tick();
        checkOutput("run_cycles_9", run_cycles, 32'd9);
        setKey(2, 24'h00ABCD);
        applyStimulus(4'b0100, 4'b0100);
        checkOutput("t1_success", 32'(success_state), 32'h4);
        checkOutput("t1_key",     32'(found_key), 32'h00ABCD);
        checkOutput("t1_stop",    32'(core_stop), 32'h1);
        checkOutput("t1_failure", 32'(failure), 32'h0);
        checkOutput("t1_busy",    32'(busy), 32'h0);
        checkOutput("t1_cycles",  run_cycles, 32'd10);
        setKey(0, 24'h111111);
        applyStimulus(4'b0001, 4'b0001);
        checkOutput("t1_hold_success", 32'(success_state), 32'h4);
        checkOutput("t1_hold_key",     32'(found_key), 32'h00ABCD);
        checkOutput("t1_hold_cycles",  run_cycles, 32'd10);

        // Restart from SUCCESS; exhaust all four cores on different cycles.
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("t2_clear_success", 32'(success_state), 32'h0);
        checkOutput("t2_clear_key",     32'(found_key), 32'h0);
        checkOutput("t2_clear_stop",    32'(core_stop), 32'h0);
        checkOutput("t2_clear_cycles",  run_cycles, 32'h0);
        tick();
        applyStimulus(4'b0001, 4'b0000);
        tick();
        applyStimulus(4'b0010, 4'b0000);
        applyStimulus(4'b0001, 4'b0000);
        applyStimulus(4'b0100, 4'b0000);
        checkOutput("t2_not_yet_failed", 32'(failure), 32'h0);
        checkOutput("t2_still_busy", 32'(busy), 32'h1);
        tick();
        applyStimulus(4'b1000, 4'b0000);
        checkOutput("t2_failure", 32'(failure), 32'h1);
        checkOutput("t2_success", 32'(success_state), 32'h0);
        checkOutput("t2_busy",    32'(busy), 32'h0);
        checkOutput("t2_stop",    32'(core_stop), 32'h0);
        checkOutput("t2_cycles",  run_cycles, 32'd7);

        // From FAIL: start clears failure on the launch edge, then core 0 hits.
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("t3_failure_cleared", 32'(failure), 32'h0);
        checkOutput("t3_core_start", 32'(core_start), 32'hF);
        tick();
        setKey(0, 24'h123456);
        applyStimulus(4'b0001, 4'b0001);
        checkOutput("t3_success", 32'(success_state), 32'h1);
        checkOutput("t3_key",     32'(found_key), 32'h123456);
        checkOutput("t3_cycles",  run_cycles, 32'd1);

        // Cores 1 and 3 hit together: lowest index wins.
        launch();
        setKey(1, 24'hC0FFEE);
        setKey(3, 24'hBADBAD);
        tick();
        applyStimulus(4'b1010, 4'b1010);
        checkOutput("t4_success", 32'(success_state), 32'h2);
        checkOutput("t4_key",     32'(found_key), 32'hC0FFEE);

        // Core 3 hit completes the done mask: success beats exhaustion.
        launch();
        applyStimulus(4'b0001, 4'b0000);
        applyStimulus(4'b0010, 4'b0000);
        applyStimulus(4'b0100, 4'b0000);
        setKey(3, 24'h7E57ED);
        applyStimulus(4'b1000, 4'b1000);
        checkOutput("t5_success", 32'(success_state), 32'h8);
        checkOutput("t5_failure", 32'(failure), 32'h0);
        checkOutput("t5_key",     32'(found_key), 32'h7E57ED);

        // Reset in the middle of RUN; later pulses are ignored.
        launch();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkAllZero("t6_reset");
        applyStimulus(4'b0101, 4'b0101);
        checkAllZero("t6_ignored");
        tick();
        checkOutput("t6_still_idle", 32'(success_state), 32'h0);
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("t6_core_start", 32'(core_start), 32'hF);
        tick();
        checkOutput("t6_core_start_single", 32'(core_start), 32'h0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
